axis2avst_rl: RTL

Converts an AXI stream into an Avalon-ST source interface with configurable ready latency, for driving Avalon-ST sinks such as MAC TX and hard-IP ports that require readyLatency > 0. It generates startofpacket, converts tkeep to empty, and optionally byte-reverses data. It also absorbs the ready-latency skew through a small register FIFO. It sits on the TX path, directly upstream of Avalon-ST consumers; it is the mirror stage of the Avalon-ST→AXI converter on RX.

---
 rtl/axis2avst_rl_pkg.sv | 12 +
 rtl/axis2avst_rl_keep2empty.sv | 25 ++
 rtl/axis2avst_rl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/axis2avst_rl_pkg.sv
// Shared constants and width helpers for the AXI-stream to Avalon-ST bridge.
package axis2avst_rl_pkg;

   // Largest readyLatency the bridge is built to absorb.
   localparam int unsigned MaxReadyLatency = 4;

   // $clog2 clamped to at least one bit, for pointer and empty fields.
   function automatic int unsigned clog2_min1(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/axis2avst_rl_keep2empty.sv
// Highest-set-bit encoder turning a byte-enable mask into an Avalon empty count.
module axis_keep2empty
   import axis2avst_rl_pkg::*;
#(
   parameter int unsigned KEEP_WIDTH  = 8,
   parameter int unsigned EMPTY_WIDTH = clog2_min1(KEEP_WIDTH)
) (
   input  logic [KEEP_WIDTH-1:0]  keep_i,
   output logic [EMPTY_WIDTH-1:0] empty_o,
   output logic                   zero_o
);

   // Highest set lane wins; holes below it are deliberately not checked.
   always_comb begin
      empty_o = EMPTY_WIDTH'(KEEP_WIDTH - 1);
      zero_o  = 1'b1;
      for (int i = 0; i < int'(KEEP_WIDTH); i++) begin
         if (keep_i[i]) begin
            empty_o = EMPTY_WIDTH'(int'(KEEP_WIDTH) - 1 - i);
            zero_o  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/axis2avst_rl.sv
// AXI-stream to Avalon-ST source bridge with configurable readyLatency.
// Beats are encoded at push time into a small register FIFO whose head drives
// the Avalon outputs directly; a ready history register enforces readyLatency.
module axis2avst_rl
   import axis2avst_rl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 64,
   parameter int unsigned KEEP_WIDTH    = DATA_WIDTH / 8,
   parameter bit          KEEP_ENABLE   = (DATA_WIDTH > 8),
   parameter int unsigned EMPTY_WIDTH   = clog2_min1(KEEP_WIDTH),
   parameter bit          BYTE_REVERSE  = 1'b0,
   parameter int unsigned READY_LATENCY = 0,
   parameter int unsigned FIFO_DEPTH    = READY_LATENCY + 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [DATA_WIDTH-1:0]  axis_tdata,
   input  logic [KEEP_WIDTH-1:0]  axis_tkeep,
   input  logic                   axis_tvalid,
   output logic                   axis_tready,
   input  logic                   axis_tlast,
   input  logic                   axis_tuser,
   output logic [DATA_WIDTH-1:0]  avst_data,
   output logic                   avst_valid,
   input  logic                   avst_ready,
   output logic                   avst_startofpacket,
   output logic                   avst_endofpacket,
   output logic [EMPTY_WIDTH-1:0] avst_empty,
   output logic                   avst_error
);

   localparam int unsigned PtrW = clog2_min1(FIFO_DEPTH);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SrW  = (READY_LATENCY > 0) ? READY_LATENCY : 1;

   localparam logic [PtrW-1:0] PtrLast = PtrW'(FIFO_DEPTH - 1);
   localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

   logic                   push;
   logic                   pop;
   logic                   rdy_ok;
   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]        count_q, count_d;
   logic                   in_pkt_q, in_pkt_d;
   logic [SrW-1:0]         rdy_sr_q, rdy_sr_d;

   logic [DATA_WIDTH-1:0]  enc_data;
   logic [EMPTY_WIDTH-1:0] enc_empty;
   logic                   enc_error;
   logic [EMPTY_WIDTH-1:0] k2e_empty;
   logic                   k2e_zero;

   logic [DATA_WIDTH-1:0]  mem_data_q  [FIFO_DEPTH];
   logic                   mem_sop_q   [FIFO_DEPTH];
   logic                   mem_eop_q   [FIFO_DEPTH];
   logic [EMPTY_WIDTH-1:0] mem_empty_q [FIFO_DEPTH];
   logic                   mem_error_q [FIFO_DEPTH];

   axis_keep2empty #(
      .KEEP_WIDTH  (KEEP_WIDTH),
      .EMPTY_WIDTH (EMPTY_WIDTH)
   ) u_keep2empty (
      .keep_i  (axis_tkeep),
      .empty_o (k2e_empty),
      .zero_o  (k2e_zero)
   );

   // Optional byte-lane mirror so lane n lands on lane KEEP_WIDTH-1-n.
   always_comb begin
      enc_data = axis_tdata;
      if (BYTE_REVERSE) begin
         for (int n = 0; n < int'(KEEP_WIDTH); n++) begin
            enc_data[n*8 +: 8] = axis_tdata[(int'(KEEP_WIDTH) - 1 - n)*8 +: 8];
         end
      end
   end

   // Sideband encode; empty and error only carry meaning on the last beat.
   always_comb begin
      enc_empty = '0;
      enc_error = 1'b0;
      if (axis_tlast) begin
         enc_error = axis_tuser;
         if (KEEP_ENABLE) begin
            enc_empty = k2e_empty;
            // A last beat with no valid bytes cannot be represented; flag it.
            if (k2e_zero) begin
               enc_error = 1'b1;
            end
         end
      end
   end

   // readyLatency 0 is a plain same-cycle handshake.
   assign rdy_ok      = (READY_LATENCY == 0) ? avst_ready : rdy_sr_q[SrW-1];
   // Registered count only, so avst_ready never reaches axis_tready.
   assign axis_tready = rst_n && (count_q < CntFull);
   assign push        = axis_tvalid && axis_tready;
   assign avst_valid  = (count_q != '0) && ((READY_LATENCY == 0) || rdy_ok);
   // With readyLatency > 0 the sink must take every valid beat.
   assign pop         = avst_valid && rdy_ok;

   assign avst_data          = mem_data_q[rd_ptr_q];
   assign avst_startofpacket = mem_sop_q[rd_ptr_q];
   assign avst_endofpacket   = mem_eop_q[rd_ptr_q];
   assign avst_empty         = mem_empty_q[rd_ptr_q];
   assign avst_error         = mem_error_q[rd_ptr_q];

   // Next-state for pointers, occupancy, packet tracking and ready history.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      in_pkt_d = in_pkt_q;
      rdy_sr_d = SrW'({rdy_sr_q, avst_ready});
      if (push) begin
         wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrW'(1);
         in_pkt_d = !axis_tlast;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         in_pkt_q <= 1'b0;
         rdy_sr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         in_pkt_q <= in_pkt_d;
         rdy_sr_q <= rdy_sr_d;
      end
   end

   // FIFO storage; cleared on reset so the idle outputs read as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_data_q[i]  <= '0;
            mem_sop_q[i]   <= 1'b0;
            mem_eop_q[i]   <= 1'b0;
            mem_empty_q[i] <= '0;
            mem_error_q[i] <= 1'b0;
         end
      end else if (push) begin
         mem_data_q[wr_ptr_q]  <= enc_data;
         mem_sop_q[wr_ptr_q]   <= !in_pkt_q;
         mem_eop_q[wr_ptr_q]   <= axis_tlast;
         mem_empty_q[wr_ptr_q] <= enc_empty;
         mem_error_q[wr_ptr_q] <= enc_error;
      end
   end

endmodule
